// File: rtl/esp_stack_unit.sv
// esp_stack_unit: stack pointer with push/pop stepping, signed adjust, load,
// one-deep {esp, depth} snapshot, depth tracking and sticky error flags.
//
// Ports:
//   clock_5        rising-edge clock for all state
//   reset          synchronous active-high reset; discards the op of its cycle
//   op             4-bit op code (0 hold, 1 load, 2 push, 3 pop, 4 adjust,
//                  5 save, 6 restore, 7-15 illegal -> hold + illegal_op)
//   alu_result_bus load value for op 1
//   adj            signed offset for op 4
//   err_clear      clears sticky flags; a new error in the same cycle wins
//   esp            current stack pointer
//   mem_addr       address of the last successful push/pop access
//   depth          pushes minus pops since last load/reset (push saturates)
//   underflow      sticky: pop attempted at depth 0
//   overflow       sticky: push below LIMIT or borrowing past 0
//   illegal_op     sticky: op 7-15 seen
//
// Optional feature macro ESP_LIMIT_CHECK_EN: when defined, a push whose result
// would lie below LIMIT (or borrow) is blocked and sets overflow. When not
// defined, overflow is tied 0 and push wraps modulo 2^WIDTH.
module esp_stack_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'hffffffff,
  parameter int unsigned STEP        = 4,
  parameter int unsigned DEPTH_W     = 16,
  parameter logic [31:0] LIMIT       = 32'h0000f000
) (
  input  logic               clock_5,
  input  logic               reset,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   alu_result_bus,
  input  logic [WIDTH-1:0]   adj,
  input  logic               err_clear,
  output logic [WIDTH-1:0]   esp,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow,
  output logic               illegal_op
);
  typedef enum logic [3:0] {
    OP_HOLD, OP_LOAD, OP_PUSH, OP_POP, OP_ADJ, OP_SAVE, OP_RESTORE
  } op_t;
  localparam logic [WIDTH-1:0]   RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]   STEP_V = WIDTH'(STEP);
  localparam logic [DEPTH_W-1:0] ONE_D  = DEPTH_W'(1);
  op_t                op_e;
  logic [WIDTH-1:0]   push_addr, esp_n, addr_n, snap_esp, snap_esp_n;
  logic [DEPTH_W-1:0] depth_n, snap_depth, snap_depth_n;
  logic               push_ok, pop_ok, uf_set, il_set;
  assign op_e      = op_t'(op);
  assign push_addr = esp - STEP_V;
  assign pop_ok    = |depth;
  assign uf_set    = op_e == OP_POP && !pop_ok;
  assign il_set    = op > 4'd6;
`ifdef ESP_LIMIT_CHECK_EN
  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  // esp < STEP means the subtraction borrowed; landing exactly on LIMIT is legal
  assign push_ok = esp >= STEP_V && push_addr >= LIMIT_V;
  always_ff @(posedge clock_5)
    if (reset) overflow <= 1'b0;
    else overflow <= (op_e == OP_PUSH && !push_ok) | (overflow & ~err_clear);
`else
  assign push_ok  = 1'b1;
  assign overflow = 1'b0;
`endif
  always_comb begin
    esp_n        = esp;
    addr_n       = mem_addr;
    depth_n      = depth;
    snap_esp_n   = snap_esp;
    snap_depth_n = snap_depth;
    case (op_e)
      OP_LOAD: begin
        esp_n   = alu_result_bus;
        depth_n = '0;
      end
      OP_PUSH: if (push_ok) begin
        esp_n   = push_addr;
        addr_n  = push_addr;
        depth_n = &depth ? depth : depth + ONE_D;
      end
      OP_POP: if (pop_ok) begin
        addr_n  = esp;
        esp_n   = esp + STEP_V;
        depth_n = depth - ONE_D;
      end
      OP_ADJ: esp_n = esp + adj;
      OP_SAVE: begin
        snap_esp_n   = esp;
        snap_depth_n = depth;
      end
      OP_RESTORE: begin
        esp_n   = snap_esp;
        depth_n = snap_depth;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock_5)
    if (reset) begin
      esp        <= RST_V;
      mem_addr   <= RST_V;
      depth      <= '0;
      snap_esp   <= RST_V;
      snap_depth <= '0;
      underflow  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      esp        <= esp_n;
      mem_addr   <= addr_n;
      depth      <= depth_n;
      snap_esp   <= snap_esp_n;
      snap_depth <= snap_depth_n;
      underflow  <= uf_set | (underflow & ~err_clear);
      illegal_op <= il_set | (illegal_op & ~err_clear);
    end
endmodule

// File: tb/tb_esp_stack_unit.sv
// tb_esp_stack_unit: directed stimulus, per-cycle model compare plus literal checks.
module tb_esp_stack_unit;
  logic        clock_5 = 0, reset = 0, err_clear = 0;
  logic [3:0]  op = 0;
  logic [31:0] alu_result_bus = 0, adj = 0;
  logic [31:0] esp, mem_addr;
  logic [15:0] depth;
  logic        underflow, overflow, illegal_op;
  int pass_cnt = 0, total_cnt = 0;
  bit chk_en = 0;
  localparam longint M = 64'h1_0000_0000;
`ifdef ESP_LIMIT_CHECK_EN
  localparam bit LIM = 1;
`else
  localparam bit LIM = 0;
`endif
  longint m_esp, m_addr, s_esp;
  int     m_depth, s_depth;
  bit     m_uf, m_ov, m_il;
  always #5 clock_5 = ~clock_5;
  esp_stack_unit dut (
    .clock_5(clock_5), .reset(reset), .op(op), .alu_result_bus(alu_result_bus),
    .adj(adj), .err_clear(err_clear), .esp(esp), .mem_addr(mem_addr),
    .depth(depth), .underflow(underflow), .overflow(overflow), .illegal_op(illegal_op)
  );
  task automatic check(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  always @(posedge clock_5) begin
    longint n;
    bit uf, ov, il;
    uf = 0; ov = 0; il = 0;
    if (reset) begin
      m_esp = 32'hffffffff; m_addr = 32'hffffffff; m_depth = 0;
      s_esp = 32'hffffffff; s_depth = 0;
      m_uf = 0; m_ov = 0; m_il = 0;
    end else begin
      case (op)
        0: ;
        1: begin m_esp = alu_result_bus; m_depth = 0; end
        2: begin
          n = m_esp - 4;
          if (LIM && (n < 0 || n < 32'h0000f000)) ov = 1;
          else begin
            m_esp = (n + M) % M;
            m_addr = m_esp;
            m_depth = m_depth == 65535 ? 65535 : m_depth + 1;
          end
        end
        3: if (m_depth == 0) uf = 1;
           else begin m_addr = m_esp; m_esp = (m_esp + 4) % M; m_depth = m_depth - 1; end
        4: m_esp = (m_esp + adj) % M;
        5: begin s_esp = m_esp; s_depth = m_depth; end
        6: begin m_esp = s_esp; m_depth = s_depth; end
        default: il = 1;
      endcase
      m_uf = uf | (m_uf & !err_clear);
      m_ov = ov | (m_ov & !err_clear);
      m_il = il | (m_il & !err_clear);
    end
  end
  always @(negedge clock_5) if (chk_en) begin
    check("model_esp", esp, m_esp);
    check("model_mem_addr", mem_addr, m_addr);
    check("model_depth", depth, m_depth);
    check("model_underflow", underflow, m_uf);
    check("model_overflow", overflow, m_ov);
    check("model_illegal_op", illegal_op, m_il);
  end
  task automatic cyc(input logic [3:0] o, input logic [31:0] a = 0, input logic [31:0] d = 0,
                     input logic c = 0, input logic r = 0);
    op = o; alu_result_bus = a; adj = d; err_clear = c; reset = r;
    @(posedge clock_5);
    #1;
    op = 0; err_clear = 0; reset = 0;
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1);
    chk_en = 1;
    check("rst_esp", esp, 32'hffffffff);
    check("rst_mem_addr", mem_addr, 32'hffffffff);
    check("rst_depth", depth, 0);
    check("rst_flags", {underflow, overflow, illegal_op}, 0);
    cyc(2); check("push1_esp", esp, 32'hfffffffb);
    cyc(2); check("push2_esp", esp, 32'hfffffff7);
    cyc(2); check("push3_esp", esp, 32'hfffffff3);
    check("push3_addr", mem_addr, 32'hfffffff3);
    check("push3_depth", depth, 3);
    cyc(3); cyc(3);
    check("pop_depth1", depth, 1);
    cyc(3);
    check("pop_last_esp", esp, 32'hffffffff);
    check("pop_last_addr", mem_addr, 32'hfffffffb);
    check("pop_last_depth", depth, 0);
    cyc(3);
    check("uf_esp", esp, 32'hffffffff);
    check("uf_set", underflow, 1);
    cyc(0, 0, 0, 1);
    check("uf_clear", underflow, 0);
    cyc(3, 0, 0, 1);
    check("uf_set_wins", underflow, 1);
    cyc(1, 32'h00001000);
    check("load_esp", esp, 32'h00001000);
    check("load_addr_kept", mem_addr, 32'hfffffffb);
    cyc(5); cyc(2); cyc(2);
    cyc(4, 0, 32'hfffffff0);
    check("adj_esp", esp, LIM ? 32'h00000ff0 : 32'h00000fe8);
    check("adj_depth", depth, LIM ? 0 : 2);
    cyc(6);
    check("restore_esp", esp, 32'h00001000);
    check("restore_depth", depth, 0);
    cyc(4'hA);
    check("illegal_esp", esp, 32'h00001000);
    check("illegal_flag", illegal_op, 1);
    cyc(2, 0, 0, 0, 1);
    check("rst_push_esp", esp, 32'hffffffff);
    check("rst_push_flags", {underflow, overflow, illegal_op}, 0);
    cyc(1, 32'h00001234); cyc(6);
    check("restore_nosave_esp", esp, 32'hffffffff);
    check("restore_nosave_depth", depth, 0);
`ifdef ESP_LIMIT_CHECK_EN
    cyc(1, 32'h0000f004); cyc(2);
    check("lim_push_ok", esp, 32'h0000f000);
    cyc(2);
    check("lim_push_blk_esp", esp, 32'h0000f000);
    check("lim_overflow", overflow, 1);
    check("lim_depth", depth, 1);
    cyc(0, 0, 0, 1);
    check("lim_ov_clear", overflow, 0);
    cyc(1, 32'h00000002); cyc(2);
    check("lim_borrow_esp", esp, 32'h00000002);
    check("lim_borrow_ov", overflow, 1);
`else
    cyc(1, 32'h00000000); cyc(2);
    check("wrap_esp", esp, 32'hfffffffc);
    check("wrap_addr", mem_addr, 32'hfffffffc);
    check("wrap_overflow", overflow, 0);
    check("wrap_depth", depth, 1);
`endif
    cyc(0); cyc(0);
    @(posedge clock_5);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
